// File: rtl/shift_arbiter_pkg.sv
// Shared widths, shift-op encodings and FSM state encodings for shift_arbiter.
package shift_arbiter_pkg;

   localparam int SA_DATA_WIDTH  = 32;
   localparam int SA_SHAMT_WIDTH = 5;

   typedef enum logic [1:0] {
      SHOP_SLL = 2'b00,
      SHOP_RSV = 2'b01,
      SHOP_SRL = 2'b10,
      SHOP_SRA = 2'b11
   } shop_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Shared combinational shifter: sll / srl / sra on an unsigned shift amount.
module shift_arbiter_shifter
   import shift_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH  = SA_DATA_WIDTH,
   parameter int SHAMT_WIDTH = SA_SHAMT_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]  i_a,
   input  logic [SHAMT_WIDTH-1:0] i_shamt,
   input  logic [1:0]             i_op,
   output logic [DATA_WIDTH-1:0]  o_result
);

   always_comb begin
      o_result = '0;
      case (i_op)
         SHOP_SLL: o_result = i_a << i_shamt;
         SHOP_SRL: o_result = i_a >> i_shamt;
         SHOP_SRA: o_result = $unsigned($signed(i_a) >>> i_shamt);
         default:  o_result = '0;
      endcase
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between two valid/ready requesters.
// Optional SHIFT_ARB_PERF_EN adds grant/conflict performance counters.
//
//   state  | meaning
//   S_IDLE | nothing in flight, a request may be accepted
//   S_EXEC | operand registers drive the shifter, result loads at cycle end
//   S_RESP | rsp<owner>_valid high; a new request may be accepted as it drains
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH  = SA_DATA_WIDTH,
   parameter int SHAMT_WIDTH = SA_SHAMT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [DATA_WIDTH-1:0]  req0_A,
   input  logic [SHAMT_WIDTH-1:0] req0_B,
   input  logic [1:0]             req0_op,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [DATA_WIDTH-1:0]  req1_A,
   input  logic [SHAMT_WIDTH-1:0] req1_B,
   input  logic [1:0]             req1_op,
   output logic                   rsp0_valid,
   input  logic                   rsp0_ready,
   output logic [DATA_WIDTH-1:0]  rsp0_result,
   output logic                   rsp1_valid,
   input  logic                   rsp1_ready,
   output logic [DATA_WIDTH-1:0]  rsp1_result
`ifdef SHIFT_ARB_PERF_EN
   ,
   output logic [31:0]            perf_grant0,
   output logic [31:0]            perf_grant1,
   output logic [31:0]            perf_conflict
`endif
);

   state_e                 r_state;
   state_e                 w_state_nxt;
   logic [DATA_WIDTH-1:0]  r_a;
   logic [SHAMT_WIDTH-1:0] r_b;
   logic [1:0]             r_op;
   logic                   r_owner;
   logic                   r_last_grant;
   logic                   r_init_done;
   logic [DATA_WIDTH-1:0]  r_result;
   logic [DATA_WIDTH-1:0]  w_shift;
   logic                   w_rsp_fire;
   logic                   w_accept;
   logic                   w_grant;

   // r_init_done keeps both readies low on the first cycle after reset release.
   assign w_rsp_fire = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);
   assign w_accept   = r_init_done && ((r_state == S_IDLE) || w_rsp_fire)
                       && (req0_valid || req1_valid);
   assign w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

   assign req0_ready  = w_accept && !w_grant;
   assign req1_ready  = w_accept && w_grant;
   assign rsp0_valid  = (r_state == S_RESP) && !r_owner;
   assign rsp1_valid  = (r_state == S_RESP) && r_owner;
   assign rsp0_result = r_result;
   assign rsp1_result = r_result;

   shift_arbiter_shifter #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHAMT_WIDTH (SHAMT_WIDTH)
   ) u_shifter (
      .i_a      (r_a),
      .i_shamt  (r_b),
      .i_op     (r_op),
      .o_result (w_shift)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_EXEC;
         S_EXEC: w_state_nxt = S_RESP;
         S_RESP: begin
            if (w_accept)        w_state_nxt = S_EXEC;
            else if (w_rsp_fire) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_init_done  <= 1'b0;
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= '0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_result     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_init_done <= 1'b1;
         if (w_accept) begin
            r_a          <= w_grant ? req1_A  : req0_A;
            r_b          <= w_grant ? req1_B  : req0_B;
            r_op         <= w_grant ? req1_op : req0_op;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
         end
         if (r_state == S_EXEC) r_result <= w_shift;
      end
   end

`ifdef SHIFT_ARB_PERF_EN
   logic [31:0] r_perf_grant0;
   logic [31:0] r_perf_grant1;
   logic [31:0] r_perf_conflict;

   // At most one requester is ever granted, so both-valid always means a loser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_grant0   <= '0;
         r_perf_grant1   <= '0;
         r_perf_conflict <= '0;
      end else begin
         if (req0_ready)               r_perf_grant0   <= r_perf_grant0 + 32'd1;
         if (req1_ready)               r_perf_grant1   <= r_perf_grant1 + 32'd1;
         if (req0_valid && req1_valid) r_perf_conflict <= r_perf_conflict + 32'd1;
      end
   end

   assign perf_grant0   = r_perf_grant0;
   assign perf_grant1   = r_perf_grant1;
   assign perf_conflict = r_perf_conflict;
`endif

endmodule
